ps2_host_tx: RTL
================

# ps2_host_tx

Host-to-device PS/2 transmitter: sends one command byte (e.g. 0xED LED set, 0xFF reset) from the FPGA to a keyboard or mouse on the same PS2C/PS2D lines the PS/2 receiver samples. It performs the clock-inhibit/request-to-send sequence, shifts out 8 data bits LSB first with odd parity and a stop bit, and checks the device acknowledge. Lines are open-drain: the block only drives low-enables, and the top level ties each pad to 0 when its enable is high, else high-Z.

## Interface
- INHIBIT_CYCLES, 5000: PS2C held low before request (100 us at 50 MHz).
- START_CYCLES, 16: PS2C and PS2D both held low before PS2C is released.
- TIMEOUT_CYCLES, 750000: maximum cycles from PS2C release to the ack bit (15 ms at 50 MHz).
- i_clk  in  1  system clock; all state on rising edge.
- i_rst_n  in  1  one clock; reset is asynchronous and active-low.
- i_PS2C  in  1  raw PS/2 clock pad level.
- i_PS2D  in  1  raw PS/2 data pad level.
- i_Valid  in  1  request to send i_Data.
- i_Data  in  8  command byte.
- o_Ready  out  1  high only in IDLE; a transfer is accepted on i_Valid && o_Ready.
- o_PS2C_oe  out  1  1 = pull PS2C low.
- o_PS2D_oe  out  1  1 = pull PS2D low.
- o_Done  out  1  one-cycle pulse at the end of every accepted transfer.
- o_Err  out  1  valid only with o_Done: 1 = no ack or timeout.

## Operation
- Input filter per line: 8-sample shift register, reset to all ones. The filtered level goes to 1 only on 8 ones and to 0 only on 8 zeros; otherwise it holds. Falling edge = filtered level 1 last cycle, 0 now.
- On accept, latch the byte into a shift register and compute parity = ~^i_Data (odd parity).
- States and transitions:
  - IDLE: both enables 0. Accept -> INHIBIT.
  - INHIBIT: PS2C_oe=1, PS2D_oe=0 for INHIBIT_CYCLES cycles -> START.
  - START: PS2C_oe=1, PS2D_oe=1 (start bit 0) for START_CYCLES cycles -> SHIFT. Clear the bit counter and timeout counter.
  - SHIFT: PS2C_oe=0. On each filtered PS2C falling edge, present the next bit with PS2D_oe = ~bit:
    - edges 1-8: data bit 0-7;
    - edge 9: parity;
    - edge 10: stop bit, PS2D_oe=0;
    - edge 11: sample filtered PS2D as ack (0 = ack) -> WAIT_IDLE.
  - WAIT_IDLE: both enables 0. Wait until filtered PS2C and PS2D are both 1 -> DONE.
  - DONE: o_Done=1 for one cycle, o_Err = ~ack -> IDLE.
- Timeout: the counter runs in SHIFT. Reaching TIMEOUT_CYCLES before edge 11 -> both enables 0 at once, then o_Done=1 and o_Err=1 on the next cycle -> IDLE. The WAIT_IDLE phase is skipped.
- i_Valid while o_Ready=0 is ignored; no queueing. i_Data is only sampled at accept.
- The filters run in every state. Edges seen outside SHIFT are ignored.

## Timing
- Reset (async assert): state=IDLE, o_PS2C_oe=0, o_PS2D_oe=0, o_Done=0, o_Err=0, o_Ready=1 combinationally from IDLE, filtered levels=1, all counters 0. Reset mid-transfer releases both lines immediately; no o_Done is produced.
- Accept at edge N:
  - o_PS2C_oe=1 from edge N+1 through N+INHIBIT_CYCLES;
  - o_PS2D_oe=1 from edge N+INHIBIT_CYCLES+1;
  - o_PS2C_oe=0 from edge N+INHIBIT_CYCLES+START_CYCLES+1.
- Raw PS2C fall to o_PS2D_oe update: exactly 9 cycles (8 filter + 1 register), well inside the device's 30 us low phase.
- Done-to-IDLE: o_Ready returns high the cycle after the o_Done pulse. Back-to-back i_Valid is accepted that same cycle.
- Simultaneous timeout expiry and edge 11 on the same cycle: the edge wins (ack sampled).

## Test plan
- Send 0xED to a device model that acks. Check:
  - PS2C low for exactly 5000 cycles;
  - device-sampled bits on PS2C rise: 0 (start), 1,0,1,1,0,1,1,1, parity 1, stop 1;
  - o_Done=1 with o_Err=0;
  - o_Ready high again on the next cycle.
- Parity sweep: 0x00 -> parity 1, 0xFF -> parity 1, 0x01 -> parity 0, 0x80 -> parity 0. All acked, o_Err=0.
- No ack: the device leaves PS2D high at its 11th clock -> o_Done=1, o_Err=1, both enables 0.
- Device never clocks: timeout fires 750000 cycles after PS2C release -> enables drop to 0, o_Done/o_Err=1 one cycle later, o_Ready=1.
- Assert i_rst_n=0 mid-bit-4 -> both enables 0 immediately, no o_Done. After release, o_Ready=1 and a fresh 0xF4 transfer completes with o_Err=0.
- Robustness:
  - a 3-cycle low glitch on PS2C during SHIFT causes no bit advance;
  - i_Valid with i_Data=0x55 held during a busy transfer is not accepted or transmitted.

Source files
------------

// File: rtl/ps2_host_tx.sv
// Purpose : host-to-device PS/2 command transmitter (inhibit, request-to-send, 11-bit frame, ack check).
// Latency : accept -> PS2C pulled low next cycle; raw PS2C fall -> PS2D enable update in 9 cycles.
// Backpr. : o_Ready only in IDLE; i_Valid while busy is dropped (no queueing), i_Data sampled at accept.
//
// Ports:
//   i_clk, i_rst_n      clock, async active-low reset
//   i_PS2C, i_PS2D      raw pad levels (filtered internally)
//   i_Valid, i_Data     command byte request, accepted on i_Valid && o_Ready
//   o_Ready             high in IDLE
//   o_PS2C_oe/o_PS2D_oe open-drain low-enables (1 = pull pad low)
//   o_Done, o_Err       one-cycle completion pulse; o_Err = no ack or timeout
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int START_CYCLES   = 16,
  parameter int TIMEOUT_CYCLES = 750000
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_PS2C,
  input  logic       i_PS2D,
  input  logic       i_Valid,
  input  logic [7:0] i_Data,
  output logic       o_Ready,
  output logic       o_PS2C_oe,
  output logic       o_PS2D_oe,
  output logic       o_Done,
  output logic       o_Err
);

  localparam int PH_MAX = (INHIBIT_CYCLES > START_CYCLES) ? INHIBIT_CYCLES : START_CYCLES;
  localparam int PH_W   = $clog2(PH_MAX + 1);
  localparam int TO_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [PH_W-1:0] INH_LAST = PH_W'(INHIBIT_CYCLES - 1);
  localparam logic [PH_W-1:0] ST_LAST  = PH_W'(START_CYCLES - 1);
  localparam logic [TO_W-1:0] TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_INHIBIT, S_START, S_SHIFT, S_WAIT_IDLE, S_ABORT, S_DONE
  } state_t;

  state_t state, state_nxt;

  // Line filters: level changes only after 8 identical samples.
  logic [7:0] c_hist, d_hist, c_hist_nxt, d_hist_nxt;
  logic       c_filt, d_filt, c_filt_d1;
  logic       c_fall;

  assign c_hist_nxt = {c_hist[6:0], i_PS2C};
  assign d_hist_nxt = {d_hist[6:0], i_PS2D};
  assign c_fall     = c_filt_d1 & ~c_filt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      c_hist    <= 8'hFF;
      d_hist    <= 8'hFF;
      c_filt    <= 1'b1;
      d_filt    <= 1'b1;
      c_filt_d1 <= 1'b1;
    end else begin
      c_hist    <= c_hist_nxt;
      d_hist    <= d_hist_nxt;
      c_filt_d1 <= c_filt;
      // Decide on the incoming history so the level moves on the 8th sample edge.
      if (&c_hist_nxt)       c_filt <= 1'b1;
      else if (~|c_hist_nxt) c_filt <= 1'b0;
      if (&d_hist_nxt)       d_filt <= 1'b1;
      else if (~|d_hist_nxt) d_filt <= 1'b0;
    end
  end

  logic [PH_W-1:0] phase_cnt;
  logic [TO_W-1:0] tmo_cnt;
  logic [3:0]      bit_cnt;
  logic [7:0]      shreg;
  logic            par_q;
  logic            d_oe_q;
  logic            err_q;

  logic edge11, timeout;
  assign edge11  = (state == S_SHIFT) && c_fall && (bit_cnt == 4'd10);
  assign timeout = (state == S_SHIFT) && (tmo_cnt == TO_LAST);

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic; the 11th clock edge wins over a coincident timeout.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:      if (i_Valid)                 state_nxt = S_INHIBIT;
      S_INHIBIT:   if (phase_cnt == INH_LAST)   state_nxt = S_START;
      S_START:     if (phase_cnt == ST_LAST)    state_nxt = S_SHIFT;
      S_SHIFT:     if (edge11)                  state_nxt = S_WAIT_IDLE;
                   else if (timeout)            state_nxt = S_ABORT;
      S_WAIT_IDLE: if (c_filt && d_filt)        state_nxt = S_DONE;
      S_ABORT:                                  state_nxt = S_DONE;
      S_DONE:                                   state_nxt = S_IDLE;
      default:                                  state_nxt = S_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    o_Ready   = (state == S_IDLE);
    o_PS2C_oe = (state == S_INHIBIT) || (state == S_START);
    o_PS2D_oe = (state == S_START) || ((state == S_SHIFT) && d_oe_q);
    o_Done    = (state == S_DONE);
    o_Err     = (state == S_DONE) && err_q;
  end

  // Datapath: phase timing, frame shifter, timeout, ack capture.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      phase_cnt <= '0;
      tmo_cnt   <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      par_q     <= 1'b0;
      d_oe_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (i_Valid) begin
            shreg     <= i_Data;
            par_q     <= ~^i_Data;
            phase_cnt <= '0;
            d_oe_q    <= 1'b1;  // start bit stays on PS2D until the first device clock
            err_q     <= 1'b0;
          end
        end
        S_INHIBIT: begin
          phase_cnt <= (phase_cnt == INH_LAST) ? '0 : phase_cnt + 1'b1;
        end
        S_START: begin
          phase_cnt <= phase_cnt + 1'b1;
          bit_cnt   <= '0;
          tmo_cnt   <= '0;
        end
        S_SHIFT: begin
          tmo_cnt <= tmo_cnt + 1'b1;
          if (c_fall) begin
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt < 4'd8) begin
              d_oe_q <= ~shreg[0];
              shreg  <= {1'b0, shreg[7:1]};
            end else if (bit_cnt == 4'd8) begin
              d_oe_q <= ~par_q;
            end else begin
              d_oe_q <= 1'b0;   // stop bit, then release for the ack
            end
          end
          if (edge11)       err_q <= d_filt;  // device pulls PS2D low to ack
          else if (timeout) err_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
